pulse_sync_multi: RTL

- Multi-channel synchroniser for asynchronous pulse or level inputs into a single clock domain, such as pads, slow external strobes, or another clock region.
- Each channel has a configurable-depth flop synchroniser, a selectable edge detector, and a pulse shaper that emits a fixed-width output pulse.
- Edges that arrive while a channel's pulse is still being emitted are either dropped or retrigger the pulse, depending on a parameter. Dropped edges set a sticky per-channel flag.
- The block replaces ad-hoc per-signal synchronisers at the input boundary of readout and trigger logic.

---
 rtl/pulse_sync_multi.sv | 103 ++++++++++
 1 files changed

// File: rtl/pulse_sync_multi.sv
// Multi-channel pulse/level synchroniser: per-channel flop synchroniser, edge
// detector and fixed-width pulse shaper with drop-or-retrigger handling.
module pulse_sync_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int OUT_WIDTH   = 1,
  parameter int RETRIGGER   = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] PULSE_IN,
  input  logic                MISSED_CLR,
  output logic [CHANNELS-1:0] PULSE_OUT,
  output logic [CHANNELS-1:0] BUSY,
  output logic [CHANNELS-1:0] MISSED
);

  localparam int              WARM_W     = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);
  localparam logic [7:0]      WIDTH_LOAD = 8'(OUT_WIDTH);

  logic [WARM_W-1:0]   warm_p0;
  logic [CHANNELS-1:0] sync_p [SYNC_STAGES];
  logic [CHANNELS-1:0] hist_p1;
  logic [CHANNELS-1:0] ev;
  logic [7:0]          cnt_p2  [CHANNELS];
  logic [7:0]          cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] pulse_nxt;
  logic [CHANNELS-1:0] set_missed;

  function automatic logic [CHANNELS-1:0] edge_detect(
    input logic [CHANNELS-1:0] s,
    input logic [CHANNELS-1:0] h
  );
    case (EDGE_MODE)
      0:       edge_detect = s & ~h;
      1:       edge_detect = ~s & h;
      default: edge_detect = s ^ h;
    endcase
  endfunction

  // Shared warm-up: events are masked until the synchroniser holds real input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      warm_p0 <= WARM_LOAD;
    end else if (warm_p0 != '0) begin
      warm_p0 <= warm_p0 - 1'b1;
    end
  end

  // Stage p0/p1: synchroniser chain and edge-history flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      hist_p1 <= '0;
    end else begin
      sync_p[0] <= PULSE_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      hist_p1 <= sync_p[SYNC_STAGES-1];
    end
  end

  always_comb begin
    ev = '0;
    if (warm_p0 == '0) ev = edge_detect(sync_p[SYNC_STAGES-1], hist_p1);
  end

  // An edge on the expiring cycle (cnt==1) is still treated as busy, so
  // back-to-back pulses always get a low cycle unless retriggering.
  always_comb begin
    pulse_nxt  = '0;
    set_missed = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_nxt[c] = cnt_p2[c];
      if (cnt_p2[c] == 8'd0) begin
        if (ev[c]) cnt_nxt[c] = WIDTH_LOAD;
      end else if (ev[c] && (RETRIGGER != 0)) begin
        cnt_nxt[c] = WIDTH_LOAD;
      end else begin
        cnt_nxt[c] = cnt_p2[c] - 8'd1;
        if (ev[c]) set_missed[c] = 1'b1;
      end
      pulse_nxt[c] = (cnt_nxt[c] != 8'd0);
    end
  end

  // Stage p2: width counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < CHANNELS; c++) cnt_p2[c] <= 8'd0;
      PULSE_OUT <= '0;
      BUSY      <= '0;
      MISSED    <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) cnt_p2[c] <= cnt_nxt[c];
      PULSE_OUT <= pulse_nxt;
      BUSY      <= pulse_nxt;
      MISSED    <= (MISSED & ~{CHANNELS{MISSED_CLR}}) | set_missed;
    end
  end

endmodule
